// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG front end: register offsets, CTRL/STATUS bit positions,
// and the collector state encoding.
// Imported by the top-level; it holds no logic of its own.
package trng_pkg;

  // Byte offsets from BASE.
  localparam logic [31:0] OFF_DATA   = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_CTRL   = 32'h8;

  // CTRL write bits.
  localparam int CTRL_EN    = 0;  // collector enable (also the only readable CTRL bit)
  localparam int CTRL_CLR   = 1;  // clear fault, uflow and repetition counter
  localparam int CTRL_FLUSH = 2;  // drop every buffered word

  // STATUS layout: [11:4] word count, [3] uflow, [2] fault, [1] busy, [0] empty.
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_BUSY      = 1;
  localparam int STAT_FAULT     = 2;
  localparam int STAT_UFLOW     = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic {
    CS_IDLE    = 1'b0,
    CS_COLLECT = 1'b1
  } coll_state_t;

endpackage

// File: rtl/trng_fifo_io_if.sv
// Native SoC memory bus seen by the TRNG front end: request from the CPU side,
// a one-cycle completion pulse with read data from the peripheral side.
// The master drives the request and holds it until trngio_ready; the slave decodes and answers.
interface trng_fifo_io_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        trngio_sel;
  logic        trngio_ready;
  logic [31:0] trngio_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  trngio_sel, trngio_ready, trngio_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output trngio_sel, trngio_ready, trngio_rdata
  );
endinterface

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO with push, pop and flush; head is shown combinationally.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees a slot in the same cycle; flush wins over push.
module trng_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_dat,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output logic [WIDTH-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && (!o_full || i_pop) && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/trng_fifo_io.sv
// Memory-mapped TRNG front end: serial bits -> WIDTH-bit words with repetition health test, buffered for DATA reads.
// Latency: register accesses complete one cycle after select; a DATA read on an empty FIFO waits for the next word.
// Backpressure: one transaction outstanding, none accepted while ready is high; collector pauses when the FIFO is full.
module trng_fifo_io
  import trng_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0300_0000,
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 4,
  parameter int          REP_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  trng_fifo_io_if.slave        bus,
  input  logic                 trng_bit,
  output logic                 trng_req
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int BIT_W = $clog2(WIDTH+1);

  coll_state_t      r_state;
  coll_state_t      w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bitcnt;
  logic [7:0]       r_rep;
  logic             r_last;
  logic             r_en;
  logic             r_fault;
  logic             r_uflow;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic             r_stall;

  logic             w_hit_data, w_hit_status, w_hit_ctrl;
  logic             w_accept, w_is_wr, w_ctrl_wr, w_data_rd;
  logic             w_en_eff, w_fault_eff, w_clr, w_flush;
  logic             w_coll_active;
  logic             w_sample, w_last_bit, w_trip, w_word_done;
  logic [WIDTH-1:0] w_word;
  logic [7:0]       w_rep_next;
  logic             w_bypass, w_push, w_pop, w_uflow_evt;
  logic [WIDTH-1:0] w_fifo_head;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full, w_fifo_empty;
  logic [31:0]      w_status;
  logic             w_unused_ok;

  // Address decode and transaction acceptance.
  assign w_hit_data     = (bus.mem_addr == BASE + OFF_DATA);
  assign w_hit_status   = (bus.mem_addr == BASE + OFF_STATUS);
  assign w_hit_ctrl     = (bus.mem_addr == BASE + OFF_CTRL);
  assign bus.trngio_sel = bus.mem_valid && (w_hit_data || w_hit_status || w_hit_ctrl);
  assign w_accept       = bus.trngio_sel && !r_ready && !r_stall;
  assign w_is_wr        = |bus.mem_wstrb;
  assign w_ctrl_wr      = w_accept && w_is_wr && w_hit_ctrl;
  assign w_data_rd      = w_accept && !w_is_wr && w_hit_data;

  // A CTRL write takes effect on its own accepting edge, so the collector sees the new values now.
  assign w_en_eff      = w_ctrl_wr ? bus.mem_wdata[CTRL_EN] : r_en;
  assign w_clr         = w_ctrl_wr && bus.mem_wdata[CTRL_CLR];
  assign w_flush       = w_ctrl_wr && bus.mem_wdata[CTRL_FLUSH];
  assign w_fault_eff   = r_fault && !w_clr;
  assign w_coll_active = r_en && !r_fault;

  // Collector datapath: first sampled bit ends up as the word MSB.
  assign w_sample    = (r_state == CS_COLLECT);
  assign w_word      = WIDTH'({r_shift, trng_bit});
  assign w_last_bit  = (r_bitcnt == BIT_W'(WIDTH-1));
  assign w_rep_next  = ((r_rep != 8'd0) && (trng_bit == r_last)) ? r_rep + 8'd1 : 8'd1;
  assign w_trip      = w_sample && (w_rep_next >= 8'(REP_LIMIT));
  assign w_word_done = w_sample && w_last_bit && !w_trip && w_en_eff;

  // A completed word goes straight to a waiting DATA read instead of into the FIFO.
  assign w_bypass    = w_word_done && (r_stall || (w_data_rd && w_fifo_empty));
  assign w_push      = w_word_done && !w_bypass;
  assign w_pop       = w_data_rd && !w_fifo_empty;
  assign w_uflow_evt = !w_bypass && !w_coll_active &&
                       (r_stall || (w_data_rd && w_fifo_empty));

  assign trng_req         = (r_state == CS_COLLECT);
  assign bus.trngio_ready = r_ready;
  assign bus.trngio_rdata = r_rdata;
  assign w_unused_ok      = &{1'b0, bus.mem_wdata[31:3]};

  trng_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_dat   (w_word),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Assemble the STATUS word from live flags and occupancy.
  always_comb begin
    w_status                          = '0;
    w_status[STAT_EMPTY]              = w_fifo_empty;
    w_status[STAT_BUSY]               = trng_req;
    w_status[STAT_FAULT]              = r_fault;
    w_status[STAT_UFLOW]              = r_uflow;
    w_status[STAT_COUNT_LSB +: 8]     = 8'(w_fifo_count);
  end

  // Collector next state: start when allowed and room exists, abort on disable or health trip.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CS_IDLE: begin
        if (w_en_eff && !w_fault_eff && (!w_fifo_full || w_pop || w_flush)) begin
          w_state_next = CS_COLLECT;
        end
      end
      CS_COLLECT: begin
        if (!w_en_eff || w_trip) begin
          w_state_next = CS_IDLE;
        end else if (w_last_bit) begin
          // The just-finished word is counted, so a full FIFO stops collection without a gap cycle.
          if (w_flush || (w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop) < CNT_W'(DEPTH))) begin
            w_state_next = CS_COLLECT;
          end else begin
            w_state_next = CS_IDLE;
          end
        end
      end
      default: w_state_next = CS_IDLE;
    endcase
  end

  // Collector state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= CS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shift register, bit counter and repetition counter; leaving COLLECT discards any partial word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_rep    <= '0;
      r_last   <= 1'b0;
    end else begin
      if (w_state_next == CS_IDLE) begin
        r_bitcnt <= '0;
        r_rep    <= '0;
      end else if (w_sample) begin
        r_shift  <= w_word;
        r_bitcnt <= w_last_bit ? '0 : r_bitcnt + BIT_W'(1);
        r_rep    <= w_rep_next;
        r_last   <= trng_bit;
      end
      if (w_clr) begin
        r_rep <= '0;
      end
    end
  end

  // Control and sticky status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en    <= 1'b1;
      r_fault <= 1'b0;
      r_uflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= bus.mem_wdata[CTRL_EN];
      end
      if (w_clr) begin
        r_fault <= 1'b0;
      end else if (w_trip) begin
        r_fault <= 1'b1;
      end
      if (w_clr) begin
        r_uflow <= 1'b0;
      end else if (w_uflow_evt) begin
        r_uflow <= 1'b1;
      end
    end
  end

  // Bus response: one-cycle ready pulse, or hold a DATA read until a word arrives or collection stops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_stall <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      if (r_stall) begin
        if (w_bypass) begin
          r_ready <= 1'b1;
          r_rdata <= 32'(w_word);
          r_stall <= 1'b0;
        end else if (!w_coll_active) begin
          r_ready <= 1'b1;
          r_stall <= 1'b0;
        end
      end else if (w_accept) begin
        if (w_is_wr) begin
          r_ready <= 1'b1;
        end else if (w_hit_status) begin
          r_ready <= 1'b1;
          r_rdata <= w_status;
        end else if (w_hit_ctrl) begin
          r_ready <= 1'b1;
          r_rdata <= {31'b0, r_en};
        end else if (!w_fifo_empty) begin
          r_ready <= 1'b1;
          r_rdata <= 32'(w_fifo_head);
        end else if (w_bypass) begin
          r_ready <= 1'b1;
          r_rdata <= 32'(w_word);
        end else if (w_coll_active) begin
          r_stall <= 1'b1;
        end else begin
          r_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_fifo_io.sv
// Directed bench for trng_fifo_io: bus reads/writes against hand-computed register values.
// The entropy source steps one bit per collector sample and restarts its sequence whenever trng_req is low.
// Outputs are sampled on the falling clock edge.
module tb_trng_fifo_io;

  localparam logic [31:0] BASE   = 32'h0300_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic clk;
  logic resetn;
  logic trng_bit;
  logic trng_req;

  int n_checks;
  int n_errs;

  // Source: mode 0 alternating starting with 1, mode 1 stuck at 1, mode 2 rotating pattern MSB first.
  int          src_mode;
  logic [31:0] src_pat;
  logic [4:0]  src_idx;

  trng_fifo_io_if bif();

  trng_fifo_io #(
    .BASE      (BASE),
    .WIDTH     (8),
    .DEPTH     (4),
    .REP_LIMIT (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bif),
    .trng_bit (trng_bit),
    .trng_req (trng_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!trng_req) src_idx <= 5'd0;
    else           src_idx <= src_idx + 5'd1;
  end

  always_comb begin
    case (src_mode)
      0:       trng_bit = ~src_idx[0];
      1:       trng_bit = 1'b1;
      default: trng_bit = src_pat[5'd31 - src_idx];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction starting at the current falling edge; returns data and cycles to ready.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      output logic [31:0] rdata, output int cyc);
    logic got;
    got   = 1'b0;
    rdata = '0;
    cyc   = 0;
    bif.mem_valid = 1'b1;
    bif.mem_addr  = addr;
    bif.mem_wdata = wdata;
    bif.mem_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (bif.trngio_ready) begin
        rdata = bif.trngio_rdata;
        got   = 1'b1;
        break;
      end
    end
    n_checks++;
    assert (got) else begin
      n_errs++;
      $error("FAIL bus_timeout addr 0x%08h: observed no ready in %0d cycles, expected ready", addr, cyc);
    end
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output int cyc);
    xfer(addr, 32'h0, 4'h0, d, cyc);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    int          c;
    xfer(addr, wdata, 4'hF, d, c);
  endtask

  initial begin
    logic [31:0] d;
    int          c;
    n_checks = 0;
    n_errs   = 0;
    src_mode = 0;
    src_pat  = 32'h0;
    resetn   = 1'b0;
    bif.mem_valid = 1'b0;
    bif.mem_addr  = 32'h0;
    bif.mem_wdata = 32'h0;
    bif.mem_wstrb = 4'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bif.trngio_ready}, 32'h0);
    chk("rst_rdata", bif.trngio_rdata, 32'h0);
    chk("rst_req",   {31'b0, trng_req}, 32'h0);

    // DATA read issued together with reset release: waits for the first collected word.
    resetn = 1'b1;
    rd(A_DATA, d, c);
    chk("first_word", d, 32'h0000_00AA);
    n_checks++;
    assert (c >= 9 && c <= 10) else begin
      n_errs++;
      $error("FAIL stall_latency: observed %0d cycles, expected 9..10", c);
    end

    // Alternating source fills the FIFO with 8'hAA and the collector parks.
    repeat (45) @(negedge clk);
    chk("full_req", {31'b0, trng_req}, 32'h0);
    rd(A_STAT, d, c);
    chk("full_status", d, 32'h0000_0040);
    rd(A_CTRL, d, c);
    chk("ctrl_rd_en", d, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, d, c);
      chk($sformatf("fifo_word%0d", i), d, 32'h0000_00AA);
      chk($sformatf("fifo_lat%0d", i), c, 1);
    end

    // Disable + flush, then underflow read.
    wr(A_CTRL, 32'h4);
    repeat (2) @(negedge clk);
    chk("dis_req", {31'b0, trng_req}, 32'h0);
    rd(A_STAT, d, c);
    chk("dis_status", d, 32'h0000_0001);
    rd(A_DATA, d, c);
    chk("uflow_data", d, 32'h0);
    chk("uflow_lat", c, 1);
    rd(A_STAT, d, c);
    chk("uflow_status", d, 32'h0000_0009);
    rd(A_CTRL, d, c);
    chk("ctrl_rd_dis", d, 32'h0);

    // Write to DATA with a single lane is ignored but completes.
    xfer(A_DATA, 32'hFFFF_FFFF, 4'b0010, d, c);
    chk("data_wr_lat", c, 1);
    rd(A_STAT, d, c);
    chk("data_wr_noeff", d, 32'h0000_0009);

    // Select decode.
    bif.mem_valid = 1'b1;
    bif.mem_addr  = BASE + 32'hC;
    #1 chk("sel_miss", {31'b0, bif.trngio_sel}, 32'h0);
    bif.mem_addr  = A_STAT;
    #1 chk("sel_hit", {31'b0, bif.trngio_sel}, 32'h1);
    bif.mem_valid = 1'b0;
    @(negedge clk);

    // Stuck-at-1 source: first word 8'hFF lands, 16th sample trips the fault.
    src_mode = 1;
    wr(A_CTRL, 32'h3);
    repeat (25) @(negedge clk);
    chk("fault_req", {31'b0, trng_req}, 32'h0);
    rd(A_STAT, d, c);
    chk("fault_status", d, 32'h0000_0014);
    rd(A_DATA, d, c);
    chk("fault_word", d, 32'h0000_00FF);
    rd(A_DATA, d, c);
    chk("fault_uflow_data", d, 32'h0);
    rd(A_STAT, d, c);
    chk("fault_uflow_status", d, 32'h0000_000D);

    // Clear fault and resume with a known pattern.
    src_mode = 2;
    src_pat  = 32'hC53A_9669;
    wr(A_CTRL, 32'h3);
    rd(A_STAT, d, c);
    chk("recover_status", d, 32'h0000_0003);
    rd(A_DATA, d, c);
    chk("recover_word", d, 32'h0000_00C5);
    repeat (45) @(negedge clk);
    rd(A_DATA, d, c);
    chk("recover_word2", d, 32'h0000_003A);
    rd(A_DATA, d, c);
    chk("recover_word3", d, 32'h0000_0096);

    // Abort mid-word: partial bits from 8'hE7 must not leak into the next word.
    wr(A_CTRL, 32'h4);
    rd(A_STAT, d, c);
    chk("abort_pre_status", d, 32'h0000_0001);
    src_pat = 32'hE7E7_E7E7;
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_req", {31'b0, trng_req}, 32'h0);
    rd(A_STAT, d, c);
    chk("abort_status", d, 32'h0000_0001);
    src_pat = 32'h5A5A_5A5A;
    wr(A_CTRL, 32'h1);
    rd(A_DATA, d, c);
    chk("abort_fresh_word", d, 32'h0000_005A);

    // Reset during a stalled DATA read.
    wr(A_CTRL, 32'h4);
    wr(A_CTRL, 32'h1);
    bif.mem_valid = 1'b1;
    bif.mem_addr  = A_DATA;
    bif.mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("stall_ready", {31'b0, bif.trngio_ready}, 32'h0);
    resetn = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, bif.trngio_ready}, 32'h0);
    chk("midrst_rdata", bif.trngio_rdata, 32'h0);
    chk("midrst_req",   {31'b0, trng_req}, 32'h0);
    bif.mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd(A_STAT, d, c);
    chk("postrst_status", d, 32'h0000_0001);
    rd(A_CTRL, d, c);
    chk("postrst_ctrl", d, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  // Hard time bound in case a wait escapes its cycle budget.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
